// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared branch/jump codes and reset PC for the fetch stage
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6
    } br_op_t;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_J    = 2'd1,
        JMP_JR   = 2'd2
    } jump_t;

    // Word offset of a conditional branch, sign-extended and scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bundle between PC/IF-ID logic and memory, hazard unit and ID
interface fetch_if;
    import fetch_pkg::*;

    logic        stall;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [31:0] pc8_d;
    br_op_t      br_op_d;
    jump_t       jump_d;
    logic        equal;
    logic        blez;
    logic        bgez;
    logic        bgtz;
    logic        bltz;
    logic [31:0] rs_data_d;
    logic        redirect_d;

    modport master (
        input  stall, instr_f, br_op_d, jump_d,
        input  equal, blez, bgez, bgtz, bltz, rs_data_d,
        output pc_f, pc_d, instr_d, pc8_d, redirect_d
    );

    modport slave (
        output stall, instr_f, br_op_d, jump_d,
        output equal, blez, bgez, bgtz, bltz, rs_data_d,
        input  pc_f, pc_d, instr_d, pc8_d, redirect_d
    );

endinterface

// File: rtl/fetch_npc_sel.sv
// rtl/fetch_npc_sel.sv - next-PC selection from ID-stage branch/jump resolution
module npc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_f,
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    input  br_op_t      br_op_d,
    input  jump_t       jump_d,
    input  logic        equal,
    input  logic        blez,
    input  logic        bgez,
    input  logic        bgtz,
    input  logic        bltz,
    input  logic [31:0] rs_data_d,
    output logic [31:0] next_pc,
    output logic        redirect_d
);

    logic        taken;
    logic [31:0] pc_d4;
    wire         unused_opcode = ^instr_d[31:26];

    assign pc_d4 = pc_d + 32'd4;

    always_comb begin
        taken = 1'b0;
        case (br_op_d)
            BR_BEQ:  taken = equal;
            BR_BNE:  taken = !equal;
            BR_BLEZ: taken = blez;
            BR_BGTZ: taken = bgtz;
            BR_BLTZ: taken = bltz;
            BR_BGEZ: taken = bgez;
            default: taken = 1'b0;
        endcase
    end

    // Jumps outrank branches in case decode ever presents both.
    always_comb begin
        next_pc = pc_f + 32'd4;
        if (jump_d == JMP_JR)
            next_pc = rs_data_d;
        else if (jump_d == JMP_J)
            next_pc = {pc_d4[31:28], instr_d[25:0], 2'b00};
        else if (taken)
            next_pc = pc_d4 + branch_offset(instr_d[15:0]);
    end

    assign redirect_d = taken | (jump_d != JMP_NONE);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and IF/ID register with one-slot delayed branching
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);

    logic [31:0] pc_f_q;
    logic [31:0] pc_d_q;
    logic [31:0] instr_d_q;
    logic [31:0] next_pc;

    npc_sel u_npc_sel (
        .pc_f       (pc_f_q),
        .pc_d       (pc_d_q),
        .instr_d    (instr_d_q),
        .br_op_d    (bus.br_op_d),
        .jump_d     (bus.jump_d),
        .equal      (bus.equal),
        .blez       (bus.blez),
        .bgez       (bus.bgez),
        .bgtz       (bus.bgtz),
        .bltz       (bus.bltz),
        .rs_data_d  (bus.rs_data_d),
        .next_pc    (next_pc),
        .redirect_d (bus.redirect_d)
    );

    // The slot instruction always moves into ID on the edge that loads the target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q    <= RESET_PC;
            pc_d_q    <= 32'd0;
            instr_d_q <= 32'd0;
        end else if (!bus.stall) begin
            pc_f_q    <= next_pc;
            pc_d_q    <= pc_f_q;
            instr_d_q <= bus.instr_f;
        end
    end

    assign bus.pc_f    = pc_f_q;
    assign bus.pc_d    = pc_d_q;
    assign bus.instr_d = instr_d_q;
    assign bus.pc8_d   = pc_d_q + 32'd8;

endmodule
